// File: rtl/alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// alu_mul_sequencer
// Computes the low 32 bits of an unsigned 32x32 product by steering the shared
// execute-stage ALU through a shift-and-add loop. No multiplier is added; only
// ADD, SLL and SRL are issued, and every ALU result is captured back into the
// internal acc / mcand / mplier registers at the edge that leaves the state
// that drove the ALU.
//
// Ports:
//   clk               clock, all state updates on the rising edge
//   reset             synchronous active-high reset
//   in_start          start request, honoured only in IDLE
//   in_a_32           multiplicand, captured when a start is accepted
//   in_b_32           multiplier, captured when a start is accepted
//   in_alu_result_32  ALUResult fed back from the ALU
//   out_alu_op_4      ALUOperation driven to the ALU
//   out_alu_a_32      ALU operand A
//   out_alu_b_32      ALU operand B
//   out_alu_shamt_5   ALU shift amount (never 0)
//   out_busy          high while the loop runs (STEP, SHL, SHR)
//   out_done          one-cycle completion pulse
//   out_product_32    accumulator; valid from out_done until the next start
// -----------------------------------------------------------------------------
module alu_mul_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_start,
   input  logic [31:0] in_a_32,
   input  logic [31:0] in_b_32,
   input  logic [31:0] in_alu_result_32,
   output logic [3:0]  out_alu_op_4,
   output logic [31:0] out_alu_a_32,
   output logic [31:0] out_alu_b_32,
   output logic [4:0]  out_alu_shamt_5,
   output logic        out_busy,
   output logic        out_done,
   output logic [31:0] out_product_32
);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_ADD = 4'b0011;
   localparam logic [3:0] ALU_SLL = 4'b0101;
   localparam logic [3:0] ALU_SRL = 4'b0110;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_STEP = 3'd1,
      S_SHL  = 3'd2,
      S_SHR  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      r_state;
   logic [31:0] r_acc;
   logic [31:0] r_mcand;
   logic [31:0] r_mplier;

   state_t      w_state_next;
   logic [31:0] w_acc_next;
   logic [31:0] w_mcand_next;
   logic [31:0] w_mplier_next;

   assign out_product_32 = r_acc;

   // State and datapath registers; reset forces IDLE with all registers cleared.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_acc    <= 32'd0;
         r_mcand  <= 32'd0;
         r_mplier <= 32'd0;
      end else begin
         r_state  <= w_state_next;
         r_acc    <= w_acc_next;
         r_mcand  <= w_mcand_next;
         r_mplier <= w_mplier_next;
      end
   end

   // Next-state, register-update and ALU-drive decode. Idle-state ALU drive
   // uses shamt=1 because the ALU treats a zero shift amount specially.
   always_comb begin
      w_state_next    = r_state;
      w_acc_next      = r_acc;
      w_mcand_next    = r_mcand;
      w_mplier_next   = r_mplier;
      out_alu_op_4    = ALU_AND;
      out_alu_a_32    = 32'd0;
      out_alu_b_32    = 32'd0;
      out_alu_shamt_5 = 5'd1;
      out_busy        = 1'b0;
      out_done        = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (in_start) begin
               w_acc_next    = 32'd0;
               w_mcand_next  = in_a_32;
               w_mplier_next = in_b_32;
               w_state_next  = S_STEP;
            end else begin
               w_state_next  = S_IDLE;
            end
         end
         S_STEP: begin
            out_alu_op_4 = ALU_ADD;
            out_alu_a_32 = r_acc;
            out_alu_b_32 = r_mcand;
            out_busy     = 1'b1;
            // Exit as soon as no multiplier bits remain: leading zeros are free.
            if (r_mplier == 32'd0) begin
               w_state_next = S_DONE;
            end else begin
               if (r_mplier[0]) begin
                  w_acc_next = in_alu_result_32;
               end else begin
                  w_acc_next = r_acc;
               end
               w_state_next = S_SHL;
            end
         end
         S_SHL: begin
            out_alu_op_4    = ALU_SLL;
            out_alu_b_32    = r_mcand;
            out_alu_shamt_5 = 5'd1;
            out_busy        = 1'b1;
            w_mcand_next    = in_alu_result_32;
            w_state_next    = S_SHR;
         end
         S_SHR: begin
            out_alu_op_4    = ALU_SRL;
            out_alu_b_32    = r_mplier;
            out_alu_shamt_5 = 5'd1;
            out_busy        = 1'b1;
            w_mplier_next   = in_alu_result_32;
            w_state_next    = S_STEP;
         end
         S_DONE: begin
            out_done     = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0011;
   localparam logic [3:0] OP_SLL = 4'b0101;
   localparam logic [3:0] OP_SRL = 4'b0110;

   logic        clk;
   logic        reset;
   logic        in_start;
   logic [31:0] in_a_32;
   logic [31:0] in_b_32;
   logic [31:0] in_alu_result_32;
   logic [3:0]  out_alu_op_4;
   logic [31:0] out_alu_a_32;
   logic [31:0] out_alu_b_32;
   logic [4:0]  out_alu_shamt_5;
   logic        out_busy;
   logic        out_done;
   logic [31:0] out_product_32;

   int n_tests = 0;
   int n_fail  = 0;

   alu_mul_sequencer dut (
      .clk              (clk),
      .reset            (reset),
      .in_start         (in_start),
      .in_a_32          (in_a_32),
      .in_b_32          (in_b_32),
      .in_alu_result_32 (in_alu_result_32),
      .out_alu_op_4     (out_alu_op_4),
      .out_alu_a_32     (out_alu_a_32),
      .out_alu_b_32     (out_alu_b_32),
      .out_alu_shamt_5  (out_alu_shamt_5),
      .out_busy         (out_busy),
      .out_done         (out_done),
      .out_product_32   (out_product_32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational ALU beside the sequencer; shifts act on operand B.
   always_comb begin
      case (out_alu_op_4)
         OP_ADD:  in_alu_result_32 = out_alu_a_32 + out_alu_b_32;
         OP_SLL:  in_alu_result_32 = out_alu_b_32 << out_alu_shamt_5;
         OP_SRL:  in_alu_result_32 = out_alu_b_32 >> out_alu_shamt_5;
         OP_AND:  in_alu_result_32 = out_alu_a_32 & out_alu_b_32;
         default: in_alu_result_32 = 32'd0;
      endcase
   end

   // Reference model: latency from the multiplier's highest set bit.
   function automatic int exp_lat(input logic [31:0] b);
      for (int i = 31; i >= 0; i--) begin
         if (b[i]) return 3 * (i + 1) + 2;
      end
      return 2;
   endfunction

   function automatic logic [31:0] exp_prod(input logic [31:0] a, input logic [31:0] b);
      longint unsigned p;
      p = longint'(a) * longint'(b);
      return p[31:0];
   endfunction

   // Runs one multiply from a negedge; returns at the negedge of the DONE cycle.
   task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                         output int done_cyc, output logic [31:0] prod,
                         output int busy_cnt, output int acc_chg, output int bad_shamt);
      logic [31:0] last;
      done_cyc = -1; prod = 32'd0; busy_cnt = 0; acc_chg = 0; bad_shamt = 0;
      in_a_32 = a; in_b_32 = b; in_start = 1'b1;
      @(posedge clk);
      #1 in_start = 1'b0;
      last = 32'd0;
      for (int n = 1; n <= 120; n++) begin
         @(negedge clk);
         if (out_busy) busy_cnt++;
         if (out_alu_shamt_5 == 5'd0) bad_shamt++;
         if ((out_alu_op_4 == OP_SLL || out_alu_op_4 == OP_SRL) && out_alu_shamt_5 != 5'd1)
            bad_shamt++;
         if (out_product_32 != last) acc_chg++;
         last = out_product_32;
         if (out_done) begin
            done_cyc = n;
            prod = out_product_32;
            break;
         end
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      n_tests++;
      if (out_busy !== 1'b0 || out_done !== 1'b0 || out_product_32 !== 32'd0 ||
          out_alu_op_4 !== OP_AND || out_alu_a_32 !== 32'd0 || out_alu_b_32 !== 32'd0 ||
          out_alu_shamt_5 !== 5'd1) begin
         n_fail++;
         $display("FAIL %s: busy=%b done=%b prod=%h op=%b a=%h b=%h shamt=%0d, required 0 0 0 0000 0 0 1",
                  tag, out_busy, out_done, out_product_32, out_alu_op_4, out_alu_a_32,
                  out_alu_b_32, out_alu_shamt_5);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_start = 1'b0; in_a_32 = 32'd0; in_b_32 = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset_state");
      reset = 1'b0;
      @(negedge clk);
      check_idle_outputs("idle_after_reset");
   endtask

   task automatic test_basic();
      int d, bc, ac, bs; logic [31:0] p;
      do_mul(32'd7, 32'd6, d, p, bc, ac, bs);
      n_tests++;
      if (d !== 11) begin n_fail++; $display("FAIL basic_latency: got %0d, required 11", d); end
      n_tests++;
      if (p !== 32'd42) begin n_fail++; $display("FAIL basic_product: got %0d, required 42", p); end
      n_tests++;
      if (ac !== 2) begin n_fail++; $display("FAIL basic_acc_writes: got %0d, required 2", ac); end
      @(negedge clk);
      n_tests++;
      if (out_done !== 1'b0 || out_product_32 !== 32'd42) begin
         n_fail++;
         $display("FAIL basic_after_done: done=%b prod=%0d, required 0 42", out_done, out_product_32);
      end
   endtask

   task automatic test_zero_mplier();
      int d, bc, ac, bs; logic [31:0] p;
      do_mul(32'd12345, 32'd0, d, p, bc, ac, bs);
      n_tests++;
      if (d !== 2 || p !== 32'd0) begin
         n_fail++; $display("FAIL zero_mplier: cyc=%0d prod=%h, required 2 0", d, p);
      end
      n_tests++;
      if (bc !== 1) begin n_fail++; $display("FAIL zero_busy: got %0d, required 1", bc); end
      @(negedge clk);
   endtask

   task automatic test_max();
      int d, bc, ac, bs; logic [31:0] p;
      do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, d, p, bc, ac, bs);
      n_tests++;
      if (d !== 98 || p !== 32'h0000_0001) begin
         n_fail++; $display("FAIL max_operands: cyc=%0d prod=%h, required 98 00000001", d, p);
      end
      n_tests++;
      if (bc !== 97) begin n_fail++; $display("FAIL max_busy: got %0d, required 97", bc); end
      @(negedge clk);
   endtask

   task automatic test_wrap_shamt();
      int d, bc, ac, bs; logic [31:0] p;
      do_mul(32'h8000_0000, 32'd2, d, p, bc, ac, bs);
      n_tests++;
      if (d !== 8 || p !== 32'd0) begin
         n_fail++; $display("FAIL wrap: cyc=%0d prod=%h, required 8 0", d, p);
      end
      n_tests++;
      if (bs !== 0) begin n_fail++; $display("FAIL shamt_nonzero: bad=%0d, required 0", bs); end
      @(negedge clk);
   endtask

   task automatic test_ignore_start();
      int d; logic [31:0] p; int busy_after;
      d = -1; p = 32'd0; busy_after = 0;
      in_a_32 = 32'd3; in_b_32 = 32'd5; in_start = 1'b1;
      @(posedge clk);
      #1 in_start = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 4) begin in_start = 1'b1; in_a_32 = 32'd9; in_b_32 = 32'd9; end
         if (n == 5) in_start = 1'b0;
         if (out_done) begin d = n; p = out_product_32; break; end
      end
      n_tests++;
      if (d !== 11 || p !== 32'd15) begin
         n_fail++; $display("FAIL ignore_start: cyc=%0d prod=%0d, required 11 15", d, p);
      end
      repeat (4) begin
         @(negedge clk);
         if (out_busy) busy_after++;
      end
      n_tests++;
      if (busy_after !== 0) begin
         n_fail++; $display("FAIL start_not_queued: busy cycles=%0d, required 0", busy_after);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a1, b1, a2, b2, p1, p2; int d1, d2, nd;
      a1 = $urandom; b1 = $urandom_range(1, 255);
      a2 = $urandom; b2 = $urandom_range(1, 255);
      d1 = -1; d2 = -1; nd = 0; p1 = 32'd0; p2 = 32'd0;
      in_a_32 = a1; in_b_32 = b1; in_start = 1'b1;
      @(posedge clk);
      #1 begin in_a_32 = a2; in_b_32 = b2; end
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (out_done) begin
            nd++;
            if (nd == 1) begin d1 = n; p1 = out_product_32; end
            else begin d2 = n; p2 = out_product_32; break; end
         end
      end
      in_start = 1'b0;
      n_tests++;
      if (d1 !== exp_lat(b1) || p1 !== exp_prod(a1, b1)) begin
         n_fail++; $display("FAIL b2b_first: cyc=%0d prod=%h, required %0d %h", d1, p1, exp_lat(b1), exp_prod(a1, b1));
      end
      n_tests++;
      if (d2 !== exp_lat(b1) + 1 + exp_lat(b2) || p2 !== exp_prod(a2, b2)) begin
         n_fail++; $display("FAIL b2b_second: cyc=%0d prod=%h, required %0d %h", d2,
                            p2, exp_lat(b1) + 1 + exp_lat(b2), exp_prod(a2, b2));
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int d, bc, ac, bs, dones; logic [31:0] p;
      dones = 0;
      in_a_32 = 32'd100; in_b_32 = 32'h0000_00F0; in_start = 1'b1;
      @(posedge clk);
      #1 in_start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1; in_start = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset_mid_run");
      reset = 1'b0; in_start = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (out_done || out_busy) dones++;
      end
      n_tests++;
      if (dones !== 0) begin
         n_fail++; $display("FAIL no_partial_done: activity cycles=%0d, required 0", dones);
      end
      reset = 1'b1; in_start = 1'b1; in_a_32 = 32'd5; in_b_32 = 32'd5;
      @(negedge clk);
      check_idle_outputs("reset_beats_start");
      reset = 1'b0; in_start = 1'b0;
      @(negedge clk);
      do_mul(32'd4, 32'd4, d, p, bc, ac, bs);
      n_tests++;
      if (d !== 11 || p !== 32'd16) begin
         n_fail++; $display("FAIL after_reset_mul: cyc=%0d prod=%0d, required 11 16", d, p);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      int d, bc, ac, bs; logic [31:0] a, b, p;
      for (int i = 0; i < 25; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if (i % 7 == 3) b = 32'd0;
         do_mul(a, b, d, p, bc, ac, bs);
         n_tests++;
         if (d !== exp_lat(b) || p !== exp_prod(a, b) || bs !== 0) begin
            n_fail++;
            $display("FAIL random_%0d: a=%h b=%h cyc=%0d prod=%h badshamt=%0d, required %0d %h 0",
                     i, a, b, d, p, bs, exp_lat(b), exp_prod(a, b));
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_mplier();
      test_max();
      test_wrap_shamt();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle controller that computes a 32-bit unsigned product (low word) by sequencing the shared 32-bit ALU through shift-and-add steps. It drives the ALU's operation, operand and shift-amount inputs itself and captures `ALUResult` back into internal registers. It sits beside the ALU in the execute stage and issues only ADD, SLL and SRL operations. No multiplier hardware is added to the datapath.

## Interface
Parameters:
- none. Data width is fixed at 32 and the ALU operation codes are fixed.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the `clk` rising edge.
- `in_start`  in  1  request to start a multiply; sampled only in IDLE.
- `in_a_32`  in  32  multiplicand; captured when start is accepted.
- `in_b_32`  in  32  multiplier; captured when start is accepted.
- `in_alu_result_32`  in  32  ALU `ALUResult` feedback.
- `out_alu_op_4`  out  4  ALU `ALUOperation`.
- `out_alu_a_32`  out  32  ALU operand A.
- `out_alu_b_32`  out  32  ALU operand B.
- `out_alu_shamt_5`  out  5  ALU shift amount.
- `out_busy`  out  1  high in STEP, SHL and SHR.
- `out_done`  out  1  one-cycle pulse in DONE.
- `out_product_32`  out  32  accumulator register; valid from `out_done` until the next accepted start.

## Operation
- ALU codes: ADD=4'b0011, SLL=4'b0101, SRL=4'b0110, AND=4'b0000.
- Internal registers:
  - `acc` (32), `mcand` (32), `mplier` (32), all reset to 0.
  - 3-bit state register, reset to IDLE.
- `out_product_32` = `acc`.
- FSM (Moore; `out_busy` and `out_done` decode from state):
  - IDLE: ALU drive op=AND, A=0, B=0, shamt=1. On `in_start`=1: `acc`<=0, `mcand`<=`in_a_32`, `mplier`<=`in_b_32`, go to STEP.
  - STEP: ALU drive op=ADD, A=`acc`, B=`mcand`.
    - If `mplier`==0: go to DONE, no register write.
    - Else: if `mplier[0]`=1 then `acc`<=`in_alu_result_32`. Go to SHL.
  - SHL: ALU drive op=SLL, B=`mcand`, shamt=5'd1, A=0. `mcand`<=`in_alu_result_32`. Go to SHR.
  - SHR: ALU drive op=SRL, B=`mplier`, shamt=5'd1, A=0. `mplier`<=`in_alu_result_32`. Go to STEP.
  - DONE: ALU drive as in IDLE. `out_done`=1. Go to IDLE unconditionally.
- Shift amount is never 0 in any state. The ALU treats shamt 0 specially, so 0 must not be driven.
- Arithmetic is modulo 2^32:
  - ADD carry-out is discarded.
  - Bits shifted out of `mcand` past bit 31 are lost.
  - Result is the low 32 bits of the unsigned product, which also equals the low word of the signed product.
- Early termination: the loop exits as soon as `mplier` reaches 0, so leading zeros of the multiplier cost nothing.
- Boundary behaviour:
  - `in_start` in STEP, SHL, SHR or DONE is ignored; it is not queued.
  - `in_start` held high continuously starts a new multiply on every entry to IDLE.
  - `in_a_32` and `in_b_32` changing after acceptance has no effect.
  - `reset` in any state returns to IDLE on that edge: registers go to 0, `out_done`=0, `out_busy`=0. No partial result is reported.
  - `reset` and `in_start` in the same cycle: reset wins.

## Timing
- ALU is combinational. Each ALU step takes exactly one cycle: drive in state S, capture at the edge leaving S.
- Let k = index of the highest set bit of `in_b_32`.
  - Cycles from the accepting edge to the DONE cycle, inclusive: 3(k+1)+2.
  - If `in_b_32`=0, the count is 2.
- Maximum latency is 98 cycles (k=31). Minimum is 2 cycles.
- `out_done` is high for exactly one cycle.
- `out_product_32` is stable from the DONE cycle until the edge that accepts the next start, where it clears to 0.
- After DONE, the earliest next accept is the following cycle (IDLE), giving back-to-back throughput of latency+1 cycles.
- Reset values: `out_busy`=0, `out_done`=0, `out_product_32`=0, `out_alu_op_4`=AND, `out_alu_a_32`=0, `out_alu_b_32`=0, `out_alu_shamt_5`=1.

## Test plan
- a=7, b=6 -> `out_done` in cycle 11 after the accept edge, product=42. Exactly two STEP cycles write `acc` (bits 1 and 2).
- a=12345, b=0 -> DONE in cycle 2, product=0. No SHL/SHR states visited and `out_busy` high for 1 cycle.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> DONE in cycle 98, product=0x00000001. Also checks wrap of `acc` and `mcand`.
- a=0x80000000, b=2 -> DONE in cycle 8, product=0. `out_alu_shamt_5` is 1 in every SHL/SHR cycle and never 0.
- Start a=3, b=5, pulse `in_start` again in cycle 4 with a=9, b=9 -> second start ignored. Product=15 in cycle 11, and the next multiply starts only after IDLE is re-entered.
- Start a=100, b=0xF0, assert `reset` in cycle 10 together with `in_start` -> IDLE next cycle, all outputs at reset values, no `out_done` pulse. A fresh start a=4, b=4 then yields 16 in cycle 11.
